// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: state encodings,
// BCD digit width and a constant clog2 helper for sizing counters.
package pong_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [2:0] {
      ST_NEWGAME = 3'd0,
      ST_PLAY    = 3'd1,
      ST_NEWBALL = 3'd2,
      ST_OVER    = 3'd3,
      ST_PAUSE   = 3'd4
   } state_e;

   // Number of bits needed to hold values 0..value-1 (minimum 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle of game-control inputs (keys, hit/miss events, frame tick)
// and sequencer outputs (state, freeze flag, balls, scores, winner).
interface pong_game_ctrl_if #(
   parameter int NUM_PLAYERS = 2
);
   logic                       frame_tick;
   logic [NUM_PLAYERS-1:0]     btn;
   logic                       pause_btn;
   logic [NUM_PLAYERS-1:0]     hit;
   logic                       miss;
   logic [2:0]                 state;
   logic                       gra_still;
   logic [3:0]                 balls_left;
   logic [8*NUM_PLAYERS-1:0]   score_bcd;
   logic [1:0]                 winner;
   logic                       winner_vld;

   // Source side: keyboard/graph units feeding the sequencer.
   modport master (
      output frame_tick, btn, pause_btn, hit, miss,
      input  state, gra_still, balls_left, score_bcd, winner, winner_vld
   );

   // Sequencer side.
   modport slave (
      input  frame_tick, btn, pause_btn, hit, miss,
      output state, gra_still, balls_left, score_bcd, winner, winner_vld
   );
endinterface

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter, saturating at 99. at_win flags that the
// value after this cycle's increment equals WIN_SCORE; it ignores clr so
// the game FSM can use it without a combinational loop through clr.
module pong_bcd_counter #(
   parameter int WIN_SCORE = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] bcd,
   output logic       at_win
);
   import pong_pkg::*;

   logic [BCD_W-1:0] ones_q, ones_d;
   logic [BCD_W-1:0] tens_q, tens_d;
   logic [6:0]       bin_s;

   assign bin_s  = ({3'd0, tens_q} * 7'd10) + {3'd0, ones_q};
   assign at_win = ((bin_s + {6'd0, inc}) == 7'(WIN_SCORE));
   assign bcd    = {tens_q, ones_q};

   // Next digit values: clear, saturating increment with carry, or hold.
   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      if (clr) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (inc) begin
         if (ones_q == 4'd9) begin
            if (tens_q != 4'd9) begin
               ones_d = 4'd0;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q;
               tens_d = tens_q;
            end
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end else begin
         ones_d = ones_q;
      end
   end

   // Digit registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end
endmodule

// File: rtl/pong_game_ctrl.sv
// N-player pong game sequencer: FSM, serve/over timer, ball counter,
// key edge detectors, winner register and per-player BCD scores.
module pong_game_ctrl #(
   parameter int NUM_PLAYERS = 2,
   parameter int BALLS       = 3,
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_TICKS = 120,
   parameter int OVER_TICKS  = 120,
   parameter int SERVE_ALL   = 1
) (
   input  logic               clk,
   input  logic               reset,
   pong_game_ctrl_if.slave    bus
);
   import pong_pkg::*;

   localparam int TMAX = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
   localparam int TW   = clog2(TMAX + 1);

   state_e                    state_q, state_d;
   logic [TW-1:0]             timer_q, timer_d, timer_dec_s;
   logic [3:0]                balls_q, balls_d;
   logic [1:0]                winner_q, winner_d, win_idx_s;
   logic                      wvld_q, wvld_d;
   logic                      still_q;
   logic                      btn_q, pause_q, armed_q;
   logic                      btn_rise_s, pause_rise_s, serve_s, score_clr_s;
   logic [NUM_PLAYERS-1:0]    inc_s, at_win_s, win_s;
   logic [8*NUM_PLAYERS-1:0]  score_s;

   // armed_q blocks the first cycle after reset so a key held through
   // reset is not mistaken for a fresh press.
   assign btn_rise_s   = armed_q & (|bus.btn) & ~btn_q;
   assign pause_rise_s = armed_q & bus.pause_btn & ~pause_q;
   assign serve_s      = (SERVE_ALL != 0) ? (&bus.btn) : (|bus.btn);
   assign timer_dec_s  = (bus.frame_tick && (timer_q != TW'(0))) ? (timer_q - TW'(1)) : timer_q;
   assign inc_s        = bus.hit & {NUM_PLAYERS{state_q == ST_PLAY}};
   assign win_s        = at_win_s & inc_s;
   assign score_clr_s  = (state_d == ST_NEWGAME);

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
      pong_bcd_counter #(.WIN_SCORE(WIN_SCORE)) u_cnt (
         .clk    (clk),
         .reset  (reset),
         .clr    (score_clr_s),
         .inc    (inc_s[g]),
         .bcd    (score_s[8*g +: 8]),
         .at_win (at_win_s[g])
      );
   end

   // Lowest-index player among those reaching the win score this cycle.
   always_comb begin
      win_idx_s = 2'd0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (win_s[i]) begin
            win_idx_s = 2'(i);
         end else begin
            win_idx_s = win_idx_s;
         end
      end
   end

   // Next-state logic: transitions, timer loads/decrements, balls and winner.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      balls_d  = balls_q;
      winner_d = winner_q;
      wvld_d   = wvld_q;
      case (state_q)
         ST_NEWGAME: begin
            balls_d = 4'(BALLS);
            wvld_d  = 1'b0;
            if (btn_rise_s) begin
               state_d = ST_PLAY;
               balls_d = 4'(BALLS - 1);
            end else begin
               state_d = ST_NEWGAME;
            end
         end
         ST_PLAY: begin
            if (|win_s) begin
               state_d  = ST_OVER;
               winner_d = win_idx_s;
               wvld_d   = 1'b1;
               timer_d  = TW'(OVER_TICKS);
            end else if (bus.miss && !(|bus.hit)) begin
               if (balls_q == 4'd0) begin
                  state_d = ST_OVER;
                  wvld_d  = 1'b0;
                  timer_d = TW'(OVER_TICKS);
               end else begin
                  state_d = ST_NEWBALL;
                  balls_d = balls_q - 4'd1;
                  timer_d = TW'(SERVE_TICKS);
               end
            end else if (pause_rise_s) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PAUSE: begin
            if (pause_rise_s) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_NEWBALL: begin
            timer_d = timer_dec_s;
            if ((timer_dec_s == TW'(0)) && serve_s) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_NEWBALL;
            end
         end
         ST_OVER: begin
            timer_d = timer_dec_s;
            if (timer_dec_s == TW'(0)) begin
               state_d = ST_NEWGAME;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_NEWGAME;
         end
      endcase
   end

   // State, counters, edge-detect history and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_NEWGAME;
         timer_q  <= TW'(0);
         balls_q  <= 4'(BALLS);
         winner_q <= 2'd0;
         wvld_q   <= 1'b0;
         still_q  <= 1'b1;
         btn_q    <= 1'b0;
         pause_q  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         balls_q  <= balls_d;
         winner_q <= winner_d;
         wvld_q   <= wvld_d;
         still_q  <= (state_d != ST_PLAY);
         btn_q    <= |bus.btn;
         pause_q  <= bus.pause_btn;
         armed_q  <= 1'b1;
      end
   end

   assign bus.state      = state_q;
   assign bus.gra_still  = still_q;
   assign bus.balls_left = balls_q;
   assign bus.score_bcd  = score_s;
   assign bus.winner     = winner_q;
   assign bus.winner_vld = wvld_q;
endmodule
